itch_order_tracker: RTL

//  Downstream of the ITCH message decoder. Consumes one decoded order message per handshake:
//  Add A/F, Exec E/C, Cancel X, Delete D, Replace U. Keeps a direct-mapped order table keyed
//  by order reference number and emits one book-update event per table change (two for U).

---
 rtl/itch_pkg.sv | 33 +++
 rtl/order_table_ram.sv | 24 ++
 rtl/itch_order_tracker.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/itch_pkg.sv
// Shared ITCH message constants, book-update kinds and the order table entry layout.
package itch_pkg;

  localparam logic [7:0] MSG_ADD      = 8'h41;  // 'A'
  localparam logic [7:0] MSG_ADD_MPID = 8'h46;  // 'F'
  localparam logic [7:0] MSG_EXEC     = 8'h45;  // 'E'
  localparam logic [7:0] MSG_EXEC_PX  = 8'h43;  // 'C'
  localparam logic [7:0] MSG_CANCEL   = 8'h58;  // 'X'
  localparam logic [7:0] MSG_DELETE   = 8'h44;  // 'D'
  localparam logic [7:0] MSG_REPLACE  = 8'h55;  // 'U'

  typedef enum logic [2:0] {
    UPD_ADD      = 3'd0,
    UPD_EXEC     = 3'd1,
    UPD_CANCEL   = 3'd2,
    UPD_DELETE   = 3'd3,
    UPD_REPL_OUT = 3'd4,
    UPD_REPL_IN  = 3'd5
  } upd_kind_e;

  typedef struct packed {
    logic [63:0] order_ref;
    logic [15:0] locate;
    logic [7:0]  side;
    logic [31:0] price;
    logic [31:0] shares;
  } order_entry_t;

  function automatic logic [31:0] min_shares(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/order_table_ram.sv
// Simple dual-port order table storage: one write port, one synchronous read port, no reset.
module order_table_ram #(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 152
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/itch_order_tracker.sv
// Direct-mapped ITCH order table; turns decoded order messages into book-update events.
module itch_order_tracker #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [7:0]       msg_type,
  input  logic [15:0]      msg_locate,
  input  logic [7:0]       msg_side,
  input  logic [63:0]      msg_order_ref,
  input  logic [63:0]      msg_new_ref,
  input  logic [31:0]      msg_shares,
  input  logic [31:0]      msg_price,
  output logic             upd_valid,
  output logic [2:0]       upd_kind,
  output logic [15:0]      upd_locate,
  output logic [7:0]       upd_side,
  output logic [31:0]      upd_price,
  output logic [31:0]      upd_delta,
  output logic [31:0]      upd_remaining,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] collision_count
);

  import itch_pkg::*;

  localparam int DEPTH = 2**ADDR_W;
  localparam int EW    = $bits(order_entry_t);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_UPDATE, S_R_LOOKUP, S_R_UPDATE
  } state_e;

  state_e            state;
  logic [7:0]        m_type;
  logic [15:0]       m_locate;
  logic [7:0]        m_side;
  logic [63:0]       m_ref;
  logic [63:0]       m_new_ref;
  logic [31:0]       m_shares;
  logic [31:0]       m_price;
  logic [DEPTH-1:0]  valid;

  logic [ADDR_W-1:0] idx, new_idx, rd_addr, wr_addr;
  logic              wr_en;
  order_entry_t      wr_data, entry;
  logic [EW-1:0]     rd_raw;
  logic              hit, is_add, is_exec, is_cancel, is_delete, is_replace;
  logic [31:0]       take, left;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign idx     = m_ref[ADDR_W-1:0];
  assign new_idx = m_new_ref[ADDR_W-1:0];
  assign entry   = order_entry_t'(rd_raw);
  // R_LOOKUP reads the replacement slot only after UPDATE has written/cleared the old one
  assign rd_addr = (state == S_R_LOOKUP) ? new_idx : idx;

  order_table_ram #(.ADDR_W(ADDR_W), .WIDTH(EW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_raw)
  );

  always_comb begin
    is_add     = (m_type == MSG_ADD) || (m_type == MSG_ADD_MPID);
    is_exec    = (m_type == MSG_EXEC) || (m_type == MSG_EXEC_PX);
    is_cancel  = (m_type == MSG_CANCEL);
    is_delete  = (m_type == MSG_DELETE);
    is_replace = (m_type == MSG_REPLACE);
    hit        = valid[idx] && (entry.order_ref == m_ref);
    take       = min_shares(m_shares, entry.shares);
    left       = entry.shares - take;
    wr_en      = 1'b0;
    wr_addr    = idx;
    wr_data    = entry;
    if (state == S_UPDATE) begin
      if (is_add) begin
        wr_en   = 1'b1;
        wr_data = '{order_ref: m_ref, locate: m_locate, side: m_side,
                    price: m_price, shares: m_shares};
      end else if (hit && (is_exec || is_cancel)) begin
        wr_en          = 1'b1;
        wr_data.shares = left;
      end
    end else if (state == S_R_UPDATE) begin
      wr_en   = 1'b1;
      wr_addr = new_idx;
      wr_data = '{order_ref: m_new_ref, locate: m_locate, side: m_side,
                  price: m_price, shares: m_shares};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      msg_ready       <= 1'b0;
      upd_valid       <= 1'b0;
      upd_kind        <= '0;
      upd_locate      <= '0;
      upd_side        <= '0;
      upd_price       <= '0;
      upd_delta       <= '0;
      upd_remaining   <= '0;
      miss_count      <= '0;
      collision_count <= '0;
      valid           <= '0;
    end else begin
      upd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (msg_valid && msg_ready) begin
            m_type    <= msg_type;
            m_locate  <= msg_locate;
            m_side    <= msg_side;
            m_ref     <= msg_order_ref;
            m_new_ref <= msg_new_ref;
            m_shares  <= msg_shares;
            m_price   <= msg_price;
            msg_ready <= 1'b0;
            state     <= S_LOOKUP;
          end else begin
            msg_ready <= 1'b1;
          end
        end
        S_LOOKUP: state <= S_UPDATE;
        S_UPDATE: begin
          state     <= S_IDLE;
          msg_ready <= 1'b1;
          if (is_add) begin
            if (valid[idx]) collision_count <= sat_inc(collision_count);
            valid[idx]    <= 1'b1;
            upd_valid     <= 1'b1;
            upd_kind      <= UPD_ADD;
            upd_locate    <= m_locate;
            upd_side      <= m_side;
            upd_price     <= m_price;
            upd_delta     <= m_shares;
            upd_remaining <= m_shares;
          end else if (is_exec || is_cancel || is_delete || is_replace) begin
            if (!hit) begin
              miss_count <= sat_inc(miss_count);
            end else begin
              upd_valid  <= 1'b1;
              upd_locate <= entry.locate;
              upd_side   <= entry.side;
              upd_price  <= entry.price;
              if (is_exec || is_cancel) begin
                upd_kind      <= is_cancel ? UPD_CANCEL : UPD_EXEC;
                upd_delta     <= take;
                upd_remaining <= left;
                if (left == '0) valid[idx] <= 1'b0;
              end else begin
                upd_kind      <= is_delete ? UPD_DELETE : UPD_REPL_OUT;
                upd_delta     <= entry.shares;
                upd_remaining <= '0;
                valid[idx]    <= 1'b0;
                if (is_replace) begin
                  m_locate  <= entry.locate;
                  m_side    <= entry.side;
                  msg_ready <= 1'b0;
                  state     <= S_R_LOOKUP;
                end
              end
            end
          end
        end
        S_R_LOOKUP: state <= S_R_UPDATE;
        S_R_UPDATE: begin
          if (valid[new_idx]) collision_count <= sat_inc(collision_count);
          valid[new_idx] <= 1'b1;
          upd_valid      <= 1'b1;
          upd_kind       <= UPD_REPL_IN;
          upd_locate     <= m_locate;
          upd_side       <= m_side;
          upd_price      <= m_price;
          upd_delta      <= m_shares;
          upd_remaining  <= m_shares;
          msg_ready      <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
